nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The module SHALL have one parameter, WORDS, default 4: the number of 4-bit nibbles per operand, legal range 2..16, operand width N = 4*WORDS.
REQ-002 The module SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: in_valid  input  1  operand request valid.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: a  input  N  operand A, unsigned/two's complement.
REQ-008 Port: b  input  N  operand B.
REQ-009 Port: cin  input  1  carry-in to the LSB.
REQ-010 Port: slice_a  output  4  current A nibble, driven to the external 4-bit ripple adder.
REQ-011 Port: slice_b  output  4  current B nibble, driven to the adder.
REQ-012 Port: slice_cin  output  1  carry into the adder (cin for nibble 0, registered carry after that).
REQ-013 Port: slice_sum  input  4  adder sum, combinational return.
REQ-014 Port: slice_carry  input  1  adder carry-out, combinational return.
REQ-015 Port: out_valid  output  1  result valid.
REQ-016 Port: out_ready  input  1  consumer accepts the result.
REQ-017 Port: sum  output  N  result, A+B+cin mod 2^N.
REQ-018 Port: cout  output  1  unsigned carry out of bit N-1.
REQ-019 Port: ovf  output  1  signed overflow.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-022 On in_valid&&in_ready at an edge, the block SHALL register a, b and cin, clear the nibble index to 0, and go to RUN.
REQ-023 In RUN with index k, slice_a/slice_b SHALL equal bits [4k+3:4k] of the registered operands, and slice_cin SHALL equal the carry register, which is loaded from cin on accept.
REQ-024 Each RUN edge SHALL write slice_sum into sum[4k+3:4k], load slice_carry into the carry register, and increment k.
REQ-025 When k = WORDS-1, the block SHALL go to DONE instead of incrementing, with cout set to slice_carry.
REQ-026 out_valid SHALL rise exactly WORDS edges after the accepting edge.
REQ-027 ovf SHALL be set in DONE as (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]), computed from the registered operands.
REQ-028 In DONE, sum/cout/ovf SHALL hold stable while out_ready=0, with no timeout.
REQ-029 On out_valid&&out_ready the block SHALL go to IDLE; sum/cout/ovf SHALL hold their last values until the next accept.
REQ-030 Requests SHALL NOT be accepted in the same cycle as a result handshake (in_ready=0 in DONE); the minimum request period is WORDS+2 cycles.
REQ-031 In IDLE and DONE, slice_a, slice_b and slice_cin SHALL be driven to 0.
REQ-032 in_valid and input changes outside IDLE SHALL be ignored.

Reset
REQ-033 When rst_n=0 at a rising edge, the block SHALL go to IDLE from any state, aborting any operation in progress.
REQ-034 During reset, sum, cout, ovf, out_valid, the index and the carry register SHALL all be 0.
REQ-035 in_ready SHALL read 1 in the first cycle after rst_n returns to 1; no result from an aborted operation SHALL ever appear.

Verification (WORDS=4, bench ties slice ports to the team's 4-bit ripple adder)
REQ-036 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, with out_valid exactly 4 edges after accept.
REQ-037 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, with slice_cin=1 on nibbles 1..3.
REQ-038 a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
REQ-039 Hold out_ready=0 for 3 cycles in DONE -> sum/cout/ovf stable, in_ready=0, new in_valid ignored; release -> IDLE next edge.
REQ-040 Assert rst_n=0 during RUN at k=2 -> out_valid=0 and sum=0 after that edge; after release, no stale result appears and a fresh request completes correctly.
REQ-041 Hold in_valid=1 continuously with out_ready=1 for 3 requests -> accepts spaced exactly 6 cycles apart, all results correct.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: sequences a WORDS-nibble add through an external
// 4-bit ripple adder, one nibble per clock, with valid/ready on both sides.
module nibble_serial_adder #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  input  logic                 cin,
  output logic [3:0]           slice_a,
  output logic [3:0]           slice_b,
  output logic                 slice_cin,
  input  logic [3:0]           slice_sum,
  input  logic                 slice_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int N  = 4 * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [KW-1:0] k_q, k_d;
  logic          run;

  assign run = (state_q == RUN);

  // Slice ports are quiet outside RUN so the external adder sees zeros.
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    if (run) begin
      slice_a   = a_q[4*k_q +: 4];
      slice_b   = b_q[4*k_q +: 4];
      slice_cin = carry_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    k_d         = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          k_d        = '0;
          sum_d      = '0;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[4*k_q +: 4] = slice_sum;
        carry_d = slice_carry;
        if (k_q == LAST) begin
          cout_d      = slice_carry;
          // slice_sum[3] is the final sum MSB on the last nibble
          ovf_d       = (a_q[N-1] == b_q[N-1]) &&
                        (slice_sum[3] != a_q[N-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WORDS=4) with a 4-bit
// ripple adder on the slice ports.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  nibble_serial_adder #(.WORDS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .slice_cin   (slice_cin),
    .slice_sum   (slice_sum),
    .slice_carry (slice_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf)
  );

  // 4-bit ripple adder
  logic [4:0] rc;
  always_comb begin
    rc[0] = slice_cin;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ rc[i];
      rc[i+1] = (slice_a[i] & slice_b[i]) |
                (rc[i] & (slice_a[i] ^ slice_b[i]));
    end
    slice_carry = rc[4];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] xa,
                        input logic [15:0] xb,
                        input logic        xc,
                        input logic [15:0] es,
                        input logic        ec,
                        input logic        eo,
                        input int          hold,
                        output logic [3:0] cins);
    logic [15:0] hs;
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~xa;
    b = ~xb;
    for (int k = 0; k < 4; k++) begin
      chk("slice_a", slice_a, xa[4*k +: 4]);
      chk("slice_b", slice_b, xb[4*k +: 4]);
      chk("busy_out_valid", out_valid, 0);
      chk("busy_in_ready", in_ready, 0);
      cins[k] = slice_cin;
      tick();
    end
    chk("latency_out_valid", out_valid, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    chk("done_in_ready", in_ready, 0);
    chk("done_slices", {slice_a, slice_b, slice_cin}, 0);
    hs = sum;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = 16'hdead;
      b = 16'hbeef;
      tick();
      chk("hold_sum", sum, es);
      chk("hold_flags", {cout, ovf}, {ec, eo});
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_sum_held", sum, hs);
    chk("idle_slices", {slice_a, slice_b, slice_cin}, 0);
  endtask

  logic [3:0]  cins;
  logic [15:0] va [3];
  logic [15:0] vb [3];
  logic [15:0] vs [3];
  logic [1:0]  vf [3];
  int          acc_cyc [3];
  int          nacc;
  int          nres;
  logic        stale;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    rst_n = 1'b1;
    chk("rst_rel_in_ready", in_ready, 1);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0, cins);
    chk("cins_1234", cins, 4'b0000);
    run_op(16'hffff, 16'h0001, 1'b0, 16'h0000, 1, 0, 0, cins);
    chk("cins_ffff", cins, 4'b1110);
    run_op(16'h7fff, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, cins);
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 0, 0, 0, cins);
    chk("cins_cin1", cins[0], 1);
    run_op(16'h8001, 16'h8002, 1'b0, 16'h0003, 1, 1, 3, cins);

    // reset in RUN at k=2
    a = 16'h5a5a;
    b = 16'h1111;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("k2_slice_a", slice_a, 4'ha);
    rst_n = 1'b0;
    tick();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale = 1'b1;
      tick();
    end
    chk("no_stale", stale, 0);
    run_op(16'habcd, 16'h1234, 1'b0, 16'hbe01, 0, 0, 0, cins);

    // back-to-back with in_valid held high
    va[0] = 16'h1111; vb[0] = 16'h2222; vs[0] = 16'h3333; vf[0] = 2'b00;
    va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 16'h0000; vf[1] = 2'b11;
    va[2] = 16'habcd; vb[2] = 16'h1234; vs[2] = 16'hbe01; vf[2] = 2'b00;
    nacc = 0;
    nres = 0;
    a = va[0];
    b = vb[0];
    cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 3; c++) begin
      if (in_ready && in_valid && nacc < 3) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      if (out_valid) begin
        chk("b2b_sum", sum, vs[nres]);
        chk("b2b_flags", {cout, ovf}, vf[nres]);
        nres++;
      end
      tick();
      if (nacc < 3) begin
        a = va[nacc];
        b = vb[nacc];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", nres, 3);
    chk("b2b_accepts", nacc, 3);
    if (nacc == 3) begin
      chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 6);
      chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 6);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
